// File: rtl/trisc_datapath.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// trisc_datapath : TRISC register-transfer datapath (PC, MAR, IR, MDR, ACC,
//                  16x8 RAM) driven by control-unit strobes C0..C14.
// Revision       : 1.0  initial release
// ============================================================================
module trisc_datapath #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          SysClock,
  input  logic          Reset,
  input  logic          C0,
  input  logic          C1,
  input  logic          C2,
  input  logic          C3,
  input  logic          C4,
  input  logic          C5,
  input  logic          C7,
  input  logic          C8,
  input  logic          C9,
  input  logic          C10,
  input  logic          C11,
  input  logic          C12,
  input  logic          C13,
  input  logic          C14,
  input  logic          LoadEn,
  input  logic [AW-1:0] LoadAddr,
  input  logic [DW-1:0] LoadData,
  output logic          LDA,
  output logic          STA,
  output logic          ADD,
  output logic          SUB,
  output logic          XOR,
  output logic          INC,
  output logic          CLR,
  output logic          JMP,
  output logic          JPZ,
  output logic          JPN,
  output logic          HLT,
  output logic          Z,
  output logic          N,
  output logic          Halted,
  output logic [AW-1:0] PCout,
  output logic [DW-1:0] ACCout,
  output logic [DW-1:0] IRout
);

  localparam logic [3:0] c_OP_LDA = 4'b0000;
  localparam logic [3:0] c_OP_STA = 4'b0001;
  localparam logic [3:0] c_OP_ADD = 4'b0010;
  localparam logic [3:0] c_OP_SUB = 4'b0011;
  localparam logic [3:0] c_OP_XOR = 4'b0100;
  localparam logic [3:0] c_OP_INC = 4'b0110;
  localparam logic [3:0] c_OP_CLR = 4'b0111;
  localparam logic [3:0] c_OP_JMP = 4'b1000;
  localparam logic [3:0] c_OP_JPZ = 4'b1001;
  localparam logic [3:0] c_OP_JPN = 4'b1010;
  localparam logic [3:0] c_OP_HLT = 4'b1111;

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] mar_q, mar_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] mdr_q, mdr_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          halted_q, halted_d;
  logic          fetched_q, fetched_d;

  logic [DW-1:0] mem_q [0:(1<<AW)-1];

  logic [3:0]    w_opcode;
  assign w_opcode = ir_q[DW-1:DW-4];

  always_comb begin
    LDA = 1'b0; STA = 1'b0; ADD = 1'b0; SUB = 1'b0;
    XOR = 1'b0; INC = 1'b0; CLR = 1'b0; JMP = 1'b0;
    JPZ = 1'b0; JPN = 1'b0; HLT = 1'b0;
    case (w_opcode)
      c_OP_LDA: LDA = 1'b1;
      c_OP_STA: STA = 1'b1;
      c_OP_ADD: ADD = 1'b1;
      c_OP_SUB: SUB = 1'b1;
      c_OP_XOR: XOR = 1'b1;
      c_OP_INC: INC = 1'b1;
      c_OP_CLR: CLR = 1'b1;
      c_OP_JMP: JMP = 1'b1;
      c_OP_JPZ: JPZ = 1'b1;
      c_OP_JPN: JPN = 1'b1;
      c_OP_HLT: HLT = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    mar_d     = mar_q;
    ir_d      = ir_q;
    mdr_d     = mdr_q;
    acc_d     = acc_q;
    halted_d  = halted_q;
    fetched_d = fetched_q;
    if (C0) begin
      pc_d      = '0;
      mar_d     = '0;
      ir_d      = '0;
      mdr_d     = '0;
      acc_d     = '0;
      halted_d  = 1'b0;
      fetched_d = 1'b0;
    end else begin
      if (C1)      pc_d = ir_q[AW-1:0];
      else if (C2) pc_d = pc_q + AW'(1);

      if (C3)      mar_d = pc_q;
      else if (C9) mar_d = ir_q[AW-1:0];

      if (C4) mdr_d = mem_q[mar_q];
      if (C5) ir_d  = mdr_q;

      if (C8)       acc_d = '0;
      else if (C11) acc_d = mdr_q;
      else if (C12) acc_d = acc_q + mdr_q;
      else if (C13) acc_d = acc_q - mdr_q;
      else if (C14) acc_d = acc_q ^ mdr_q;
      else if (C7)  acc_d = acc_q + DW'(1);

      // A freshly fetched HLT halts unless the FSM advances PC past it.
      if (fetched_q && HLT && !C2) halted_d = 1'b1;
      fetched_d = C5;
    end
  end

  always_ff @(posedge SysClock or posedge Reset) begin
    if (Reset) begin
      pc_q      <= '0;
      mar_q     <= '0;
      ir_q      <= '0;
      mdr_q     <= '0;
      acc_q     <= '0;
      halted_q  <= 1'b0;
      fetched_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      mar_q     <= mar_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      acc_q     <= acc_d;
      halted_q  <= halted_d;
      fetched_q <= fetched_d;
    end
  end

  // Memory survives Reset and C0; an aborted instruction must not store.
  always_ff @(posedge SysClock) begin
    if (!C0) begin
      if (LoadEn)              mem_q[LoadAddr] <= LoadData;
      else if (C10 && !Reset)  mem_q[mar_q]    <= acc_q;
    end
  end

  assign Z      = (acc_q == '0);
  assign N      = acc_q[DW-1];
  assign Halted = halted_q;
  assign PCout  = pc_q;
  assign ACCout = acc_q;
  assign IRout  = ir_q;

endmodule
`default_nettype wire

// File: tb/tb_trisc_datapath.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_trisc_datapath : scoreboard bench with a behavioural datapath model.
// Revision          : 1.0  initial release
// ============================================================================
module tb_trisc_datapath;

  logic        SysClock = 1'b0;
  logic        Reset    = 1'b0;
  logic [14:0] s        = '0;
  logic        LoadEn   = 1'b0;
  logic [3:0]  LoadAddr = '0;
  logic [7:0]  LoadData = '0;
  logic LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT;
  logic Z, N, Halted;
  logic [3:0] PCout;
  logic [7:0] ACCout, IRout;

  always #5 SysClock = ~SysClock;

  trisc_datapath #(.DW(8), .AW(4)) dut (
    .SysClock(SysClock), .Reset(Reset),
    .C0(s[0]), .C1(s[1]), .C2(s[2]), .C3(s[3]), .C4(s[4]), .C5(s[5]),
    .C7(s[7]), .C8(s[8]), .C9(s[9]), .C10(s[10]), .C11(s[11]),
    .C12(s[12]), .C13(s[13]), .C14(s[14]),
    .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
    .LDA(LDA), .STA(STA), .ADD(ADD), .SUB(SUB), .XOR(XOR), .INC(INC),
    .CLR(CLR), .JMP(JMP), .JPZ(JPZ), .JPN(JPN), .HLT(HLT),
    .Z(Z), .N(N), .Halted(Halted),
    .PCout(PCout), .ACCout(ACCout), .IRout(IRout)
  );

  typedef struct packed {
    logic [3:0]  pc;
    logic [7:0]  acc;
    logic [7:0]  ir;
    logic        z;
    logic        n;
    logic        halted;
    logic [10:0] dec;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Architectural state of the reference model.
  int m_pc, m_mar, m_ir, m_mdr, m_acc;
  bit m_halt, m_fetched;
  int m_mem[16];

  function automatic logic [14:0] B(input int n);
    logic [14:0] one;
    one = 15'd1;
    return one << n;
  endfunction

  function automatic logic [10:0] dec_of(input int ir);
    int op;
    op = ir / 16;
    return {op == 0, op == 1, op == 2, op == 3, op == 4, op == 6,
            op == 7, op == 8, op == 9, op == 10, op == 15};
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.pc     = 4'(m_pc);
    o.acc    = 8'(m_acc);
    o.ir     = 8'(m_ir);
    o.z      = (m_acc == 0);
    o.n      = (m_acc >= 128);
    o.halted = m_halt;
    o.dec    = dec_of(m_ir);
    return o;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_mar = 0; m_ir = 0; m_mdr = 0; m_acc = 0;
    m_halt = 0; m_fetched = 0;
  endtask

  task automatic model_step(input logic [14:0] st, input bit le,
                            input int la, input int ld);
    int npc, nmar, nir, nmdr, nacc;
    if (st[0]) begin
      model_reset();
      return;
    end
    npc  = st[1] ? m_ir % 16 : st[2] ? (m_pc + 1) % 16 : m_pc;
    nmar = st[3] ? m_pc : st[9] ? m_ir % 16 : m_mar;
    nmdr = st[4] ? m_mem[m_mar] : m_mdr;
    nir  = st[5] ? m_mdr : m_ir;
    if (st[8])       nacc = 0;
    else if (st[11]) nacc = m_mdr;
    else if (st[12]) nacc = (m_acc + m_mdr) % 256;
    else if (st[13]) nacc = (m_acc - m_mdr + 256) % 256;
    else if (st[14]) nacc = m_acc ^ m_mdr;
    else if (st[7])  nacc = (m_acc + 1) % 256;
    else             nacc = m_acc;
    if (le)          m_mem[la]    = ld;
    else if (st[10]) m_mem[m_mar] = m_acc;
    if (m_fetched && m_ir / 16 == 15 && !st[2]) m_halt = 1;
    m_fetched = st[5];
    m_pc = npc; m_mar = nmar; m_mdr = nmdr; m_ir = nir; m_acc = nacc;
  endtask

  task automatic cyc(input logic [14:0] st, input bit le = 0,
                     input int la = 0, input int ld = 0);
    @(negedge SysClock);
    s        = st;
    LoadEn   = le;
    LoadAddr = 4'(la);
    LoadData = 8'(ld);
    model_step(st, le, la, ld);
    exp_q.push_back(model_obs());
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic settle();
    @(posedge SysClock);
    #2;
  endtask

  // Monitor: every rising edge that has a pending expectation is compared.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge SysClock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{PCout, ACCout, IRout, Z, N, Halted,
              {LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT}};
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL scoreboard t=%0t: got pc=%h acc=%h ir=%h z=%b n=%b halt=%b dec=%b expected pc=%h acc=%h ir=%h z=%b n=%b halt=%b dec=%b",
                      $time, a.pc, a.acc, a.ir, a.z, a.n, a.halted, a.dec,
                      e.pc, e.acc, e.ir, e.z, e.n, e.halted, e.dec);
      end
    end
  end

  initial begin
    int guard;
    logic [14:0] st;

    // Power-on reset.
    model_reset();
    #2 Reset = 1'b1;
    #10;
    chk("por_pc", int'(PCout), 0);
    chk("por_lda_z", int'({LDA, Z, N}), 3'b110);
    @(negedge SysClock);
    Reset = 1'b0;

    // Preload the whole RAM, with fixed values where directed tests need them.
    for (int i = 0; i < 16; i++) begin
      int v;
      v = int'($urandom_range(0, 255));
      case (i)
        0: v = 'h5A;  3: v = 'h21;  4: v = 'hF0;  5: v = 'h10;
        7: v = 'h01;  8: v = 'h8C;  11: v = 'h39; 12: v = 'h11;
        13: v = 'h22;
        default: ;
      endcase
      cyc('0, 1, i, v);
    end

    // ACC=0x5A, PC=7, then reset between edges.
    cyc(B(0)); cyc(B(3)); cyc(B(4)); cyc(B(11));
    repeat (7) cyc(B(2));
    settle();
    chk("pre_reset_acc", int'(ACCout), 'h5A);
    chk("pre_reset_pc", int'(PCout), 7);
    @(negedge SysClock);
    s = '0; LoadEn = 1'b0;
    #2 Reset = 1'b1;
    #1;
    model_reset();
    chk("reset_pc", int'(PCout), 0);
    chk("reset_acc", int'(ACCout), 0);
    chk("reset_ir", int'(IRout), 0);
    chk("reset_flags", int'({LDA, Z, N, Halted}), 4'b1100);
    @(negedge SysClock);
    Reset = 1'b0;

    // RAM[3] survives reset.
    repeat (3) cyc(B(2));
    cyc(B(3)); cyc(B(4)); cyc(B(11));
    settle();
    chk("ram3_kept", int'(ACCout), 'h21);

    // Fetch ADD 5.
    cyc('0, 1, 0, 'h25);
    cyc(B(0)); cyc(B(3)); cyc(B(4)); cyc(B(5)); cyc('0);
    settle();
    chk("fetch_ir", int'(IRout), 'h25);
    chk("fetch_dec", int'({LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT}), 11'b00100000000);
    cyc(B(2));

    // Arithmetic.
    cyc(B(8)); repeat (5) cyc(B(7));
    cyc(B(9)); cyc(B(4)); cyc(B(12));
    settle();
    chk("add", int'(ACCout), 'h15);
    cyc(B(13)); cyc(B(14));
    cyc(B(8)); repeat (6) cyc(B(2));
    cyc(B(3)); cyc(B(4)); cyc(B(13));
    settle();
    chk("sub_wrap", int'({ACCout, N, Z}), {8'hFF, 2'b10});

    // Priority.
    cyc(B(8) | B(11) | B(7));
    cyc(B(2)); cyc(B(3)); cyc(B(4)); cyc(B(5));
    cyc(B(1) | B(2));
    settle();
    chk("pc_c1_over_c2", int'(PCout), 12);
    cyc(B(2)); cyc(B(3) | B(9)); cyc(B(4)); cyc(B(11));

    // Store, with preload taking priority over C10.
    cyc(B(0)); repeat (11) cyc(B(2));
    cyc(B(3)); cyc(B(4)); cyc(B(5) | B(11));
    repeat (3) cyc(B(7));
    cyc(B(9));
    cyc(B(10), 1, 2, 'h77);
    cyc(B(10));
    cyc(B(8)); cyc(B(4)); cyc(B(11));
    settle();
    chk("store_ram9", int'(ACCout), 'h3C);
    cyc(B(0)); repeat (2) cyc(B(2));
    cyc(B(3)); cyc(B(4)); cyc(B(11));

    // Wrap-around.
    repeat (13) cyc(B(2));
    cyc(B(2));
    cyc('0, 1, 2, 'hFF);
    cyc(B(4)); cyc(B(11)); cyc(B(7));
    settle();
    chk("acc_wrap", int'({ACCout, Z, PCout}), {8'h00, 1'b1, 4'h0});

    // Halt.
    cyc(B(0)); repeat (4) cyc(B(2));
    cyc(B(3)); cyc(B(4)); cyc(B(5)); cyc('0);
    settle();
    chk("halted_set", int'(Halted), 1);
    cyc('0); cyc(B(0));

    // Randomised strobe traffic.
    repeat (600) begin
      st = '0;
      for (int k = 1; k < 15; k++) st[k] = ($urandom_range(0, 3) == 0);
      st[6] = 1'b0;
      st[0] = ($urandom_range(0, 15) == 0);
      cyc(st, $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)),
          int'($urandom_range(0, 255)));
    end
    cyc('0); cyc('0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge SysClock);
      guard++;
    end
    #3;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
